fp_led_shifter: RTL and testbench

Front-panel LED driver, directly downstream of the CPU control block. Consumes the register mirror it publishes (pc, sr, acc, x, y, sp) and shifts a 56-bit frame serially into a daisy-chain of seven 74HC595-style shift registers. After all 56 bits it pulses the storage latch. Frames are snapshotted atomically, so panel LEDs never show a torn value.

---
 rtl/fp_panel_pkg.sv | 44 ++++
 rtl/fp_phase_timer.sv | 35 +++
 rtl/fp_led_shifter.sv | 113 +++++++++++
 tb/tb_fp_led_shifter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_panel_pkg.sv
// Shared front-panel definitions: frame geometry, FSM states and the field layout of
// the 56-bit LED frame. Keep this layout in step with any panel readback logic.
package fp_panel_pkg;

    localparam int FRAME_BITS = 56;

    // Bit offsets of each 8-bit field within F[55:0]; F[55] leaves the chain first.
    localparam int PC_HI_OFS = 48;
    localparam int PC_LO_OFS = 40;
    localparam int SR_OFS    = 32;
    localparam int ACC_OFS   = 24;
    localparam int X_OFS     = 16;
    localparam int Y_OFS     = 8;
    localparam int SP_OFS    = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SH_LO = 3'd1,
        ST_SH_HI = 3'd2,
        ST_LATCH = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [15:0] pc,
        input logic [7:0]  sr,
        input logic [7:0]  acc,
        input logic [7:0]  x,
        input logic [7:0]  y,
        input logic [7:0]  sp
    );
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[PC_HI_OFS +: 8] = pc[15:8];
        f[PC_LO_OFS +: 8] = pc[7:0];
        f[SR_OFS    +: 8] = sr;
        f[ACC_OFS   +: 8] = acc;
        f[X_OFS     +: 8] = x;
        f[Y_OFS     +: 8] = y;
        f[SP_OFS    +: 8] = sp;
        return f;
    endfunction

endpackage

// File: rtl/fp_phase_timer.sv
// Down-counter for phase timing: start loads len-1, expire is high on the last cycle of the phase.
// Zero latency (len=1 expires on the first cycle); no backpressure, runs freely once started.
module fp_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] len,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = len - W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/fp_led_shifter.sv
// Front-panel LED driver: snapshots the CPU register mirror and shifts it MSB first into a 595 chain.
// Frame period 1 + 113*CLK_DIV + GAP_CYCLES clk cycles; no backpressure, inputs are sampled only in IDLE.
module fp_led_shifter
    import fp_panel_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        refresh_en,
    input  logic [7:0]  acc,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [7:0]  sp,
    input  logic [15:0] pc,
    input  logic [7:0]  sr,
    output logic        sclk,
    output logic        sdata,
    output logic        latch,
    output logic        oe_n,
    output logic        frame_done
);

    localparam int MAXLEN = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int TW     = $clog2(MAXLEN + 1);
    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] sr56_q, sr56_d;
    logic [5:0]            bitcnt_q, bitcnt_d;
    logic                  sclk_q, sdata_q, latch_q, oe_n_q, frame_done_q;

    logic                  timer_start;
    logic [TW-1:0]         timer_len;
    logic                  phase_end;

    fp_phase_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (timer_start),
        .len    (timer_len),
        .expire (phase_end)
    );

    always_comb begin
        state_d  = state_q;
        sr56_d   = sr56_q;
        bitcnt_d = bitcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (refresh_en) begin
                    sr56_d   = pack_frame(pc, sr, acc, x, y, sp);
                    bitcnt_d = '0;
                    state_d  = ST_SH_LO;
                end
            end
            ST_SH_LO: begin
                if (phase_end) state_d = ST_SH_HI;
            end
            ST_SH_HI: begin
                if (phase_end) begin
                    sr56_d   = {sr56_q[FRAME_BITS-2:0], 1'b0};
                    bitcnt_d = bitcnt_q + 6'd1;
                    state_d  = (bitcnt_q == LAST_BIT) ? ST_LATCH : ST_SH_LO;
                end
            end
            ST_LATCH: begin
                if (phase_end) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (phase_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Every state change except the return to IDLE opens a new timed phase.
        timer_start = (state_d != state_q) && (state_d != ST_IDLE);
        timer_len   = (state_d == ST_GAP) ? TW'(GAP_CYCLES) : TW'(CLK_DIV);
    end

    // Outputs are registered from the next state so they line up exactly with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sr56_q       <= '0;
            bitcnt_q     <= '0;
            sclk_q       <= 1'b0;
            sdata_q      <= 1'b0;
            latch_q      <= 1'b0;
            oe_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr56_q       <= sr56_d;
            bitcnt_q     <= bitcnt_d;
            sclk_q       <= (state_d == ST_SH_HI);
            sdata_q      <= ((state_d == ST_SH_LO) || (state_d == ST_SH_HI)) && sr56_d[FRAME_BITS-1];
            latch_q      <= (state_d == ST_LATCH);
            frame_done_q <= (state_d == ST_GAP) && (state_q != ST_GAP);
            if (state_d == ST_GAP) begin
                oe_n_q <= 1'b0;
            end
        end
    end

    assign sclk       = sclk_q;
    assign sdata      = sdata_q;
    assign latch      = latch_q;
    assign oe_n       = oe_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fp_led_shifter.sv
// Bench for fp_led_shifter: a 595-chain model behind two instances (default and CLK_DIV=1/GAP=1),
// checked against frame values computed from the register fields.
module tb_fp_led_shifter;

    localparam int CD0  = 2;
    localparam int GP0  = 4;
    localparam int CD1  = 1;
    localparam int GP1  = 1;
    localparam int PER0 = 1 + 113 * CD0 + GP0;
    localparam int PER1 = 1 + 113 * CD1 + GP1;
    localparam int NV   = 4;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  sr;
        logic [7:0]  acc;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [7:0]  sp;
        logic [55:0] exp_frame;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst1_n, refresh_en, refresh1;
    logic [15:0] pc;
    logic [7:0]  sr, acc, x, y, sp;
    logic [15:0] pc1;
    logic [7:0]  b1;
    logic        sclk, sdata, latch, oe_n, frame_done;
    logic        sclk1, sdata1, latch1, oe_n1, frame_done1;

    fp_led_shifter #(.CLK_DIV(CD0), .GAP_CYCLES(GP0)) dut0 (
        .clk(clk), .rst_n(rst_n), .refresh_en(refresh_en),
        .acc(acc), .x(x), .y(y), .sp(sp), .pc(pc), .sr(sr),
        .sclk(sclk), .sdata(sdata), .latch(latch), .oe_n(oe_n), .frame_done(frame_done)
    );

    fp_led_shifter #(.CLK_DIV(CD1), .GAP_CYCLES(GP1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .refresh_en(refresh1),
        .acc(b1), .x(b1), .y(b1), .sp(b1), .pc(pc1), .sr(b1),
        .sclk(sclk1), .sdata(sdata1), .latch(latch1), .oe_n(oe_n1), .frame_done(frame_done1)
    );

    // 595 chain models: shift on sclk rise, copy to storage on latch rise.
    logic [55:0] chain0 = '0, store0 = '0, chain1 = '0, store1 = '0;
    int sclk_n0 = 0, latch_n0 = 0, sclk_n1 = 0, latch_n1 = 0;
    int overlap = 0;
    int cyc = 0;

    always @(posedge sclk) begin
        chain0  <= {chain0[54:0], sdata};
        sclk_n0 <= sclk_n0 + 1;
    end
    always @(posedge latch) begin
        store0   <= chain0;
        latch_n0 <= latch_n0 + 1;
    end
    always @(posedge sclk1) begin
        chain1  <= {chain1[54:0], sdata1};
        sclk_n1 <= sclk_n1 + 1;
    end
    always @(posedge latch1) begin
        store1   <= chain1;
        latch_n1 <= latch_n1 + 1;
    end
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ((latch && sclk) || (latch1 && sclk1)) overlap <= overlap + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [55:0] model(input logic [15:0] p, input logic [7:0] s,
                                          input logic [7:0] a, input logic [7:0] xx,
                                          input logic [7:0] yy, input logic [7:0] ss);
        logic [7:0]  b [7];
        logic [55:0] v;
        b = '{p[15:8], p[7:0], s, a, xx, yy, ss};
        v = '0;
        for (int i = 0; i < 7; i++) v = (v << 8) | 56'(b[i]);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic wait_fd(input int which);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((((which == 0) ? frame_done : frame_done1) !== 1'b1) && (k < 2000));
        if (k >= 2000) timeout("frame_done_wait");
    endtask

    task automatic wait_rises(input int base, input int n);
        int k;
        k = 0;
        while ((sclk_n0 - base < n) && (k < 2000)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) timeout("sclk_rise_wait");
    endtask

    task automatic apply(input vec_t v);
        pc = v.pc; sr = v.sr; acc = v.acc; x = v.x; y = v.y; sp = v.sp;
    endtask

    task automatic scramble();
        pc  = 16'($urandom);
        sr  = 8'($urandom);
        acc = 8'($urandom);
        x   = 8'($urandom);
        y   = 8'($urandom);
        sp  = 8'($urandom);
    endtask

    vec_t        vec [NV];
    int          t_cyc, t_s, t_l, viol, fdc, adj;
    logic [55:0] exp_a, exp_b;

    initial begin
        rst_n = 1'b0; rst1_n = 1'b0; refresh_en = 1'b0; refresh1 = 1'b0;
        pc = '0; sr = '0; acc = '0; x = '0; y = '0; sp = '0;
        pc1 = 16'hAAAA; b1 = 8'hAA;

        vec[0] = '{16'hC0DE, 8'h24, 8'h5A, 8'h01, 8'h80, 8'hFD, 56'hC0DE245A0180FD};
        for (int i = 1; i < NV; i++) begin
            vec[i].pc  = 16'($urandom);
            vec[i].sr  = 8'($urandom);
            vec[i].acc = 8'($urandom);
            vec[i].x   = 8'($urandom);
            vec[i].y   = 8'($urandom);
            vec[i].sp  = 8'($urandom);
            vec[i].exp_frame = model(vec[i].pc, vec[i].sr, vec[i].acc, vec[i].x, vec[i].y, vec[i].sp);
        end

        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 0);
        check("rst_sdata", sdata, 0);
        check("rst_latch", latch, 0);
        check("rst_oe_n", oe_n, 1);
        check("rst_frame_done", frame_done, 0);
        check("rst_oe_n_inst1", oe_n1, 1);

        // Known frame, then a table of random frames with inputs scrambled mid-frame.
        rst_n = 1'b1;
        apply(vec[0]);
        refresh_en = 1'b1;
        repeat (20) @(negedge clk);
        check("oe_n_before_first_gap", oe_n, 1);
        wait_fd(0);
        check("frame0_data", store0, vec[0].exp_frame);
        check("oe_n_first_gap", oe_n, 0);
        t_cyc = cyc; t_s = sclk_n0; t_l = latch_n0;
        for (int i = 1; i < NV; i++) begin
            apply(vec[i]);
            repeat (30) @(negedge clk);
            scramble();
            wait_fd(0);
            check("table_frame_data", store0, vec[i].exp_frame);
            check("table_period", cyc - t_cyc, PER0);
            check("table_sclk_rises", sclk_n0 - t_s, 56);
            check("table_latch_pulses", latch_n0 - t_l, 1);
            t_cyc = cyc; t_s = sclk_n0; t_l = latch_n0;
        end

        // acc changes at sclk edge 20: this frame keeps the snapshot, the next picks it up.
        acc = 8'h00;
        exp_a = model(pc, sr, 8'h00, x, y, sp);
        exp_b = model(pc, sr, 8'hFF, x, y, sp);
        t_s = sclk_n0;
        wait_rises(t_s, 20);
        acc = 8'hFF;
        wait_fd(0);
        check("acc_snapshot_frame", store0, exp_a);
        wait_fd(0);
        check("acc_next_frame", store0, exp_b);

        // refresh_en drops at sclk edge 10: frame completes, then the block stays quiet.
        t_s = sclk_n0; t_l = latch_n0;
        wait_rises(t_s, 10);
        refresh_en = 1'b0;
        wait_fd(0);
        check("drop_sclk_rises", sclk_n0 - t_s, 56);
        check("drop_latch_pulses", latch_n0 - t_l, 1);
        viol = 0; fdc = 0;
        repeat (500) begin
            @(negedge clk);
            if (sclk || latch || sdata) viol++;
            if (frame_done) fdc++;
        end
        check("idle_outputs_quiet", viol, 0);
        check("idle_no_frame_done", fdc, 0);

        // Reset at sclk edge 30, then a clean frame after release.
        refresh_en = 1'b1;
        wait_fd(0);
        t_s = sclk_n0;
        wait_rises(t_s, 30);
        t_l = latch_n0;
        rst_n = 1'b0;
        #1;
        check("midrst_sclk", sclk, 0);
        check("midrst_sdata", sdata, 0);
        check("midrst_latch", latch, 0);
        check("midrst_oe_n", oe_n, 1);
        repeat (3) @(negedge clk);
        scramble();
        exp_a = model(pc, sr, acc, x, y, sp);
        t_s = sclk_n0;
        rst_n = 1'b1;
        wait_fd(0);
        check("postrst_frame_data", store0, exp_a);
        check("postrst_sclk_rises", sclk_n0 - t_s, 56);
        check("postrst_latch_pulses", latch_n0 - t_l, 1);
        check("postrst_oe_n", oe_n, 0);

        // CLK_DIV=1, GAP_CYCLES=1 instance with alternating data.
        rst1_n = 1'b1;
        refresh1 = 1'b1;
        wait_fd(1);
        t_cyc = cyc; t_s = sclk_n1;
        wait_fd(1);
        check("div1_period", cyc - t_cyc, PER1);
        check("div1_sclk_rises", sclk_n1 - t_s, 56);
        check("div1_frame_data", store1, model(pc1, b1, b1, b1, b1, b1));
        adj = 0;
        for (int i = 0; i < 55; i++) if (store1[i] != store1[i+1]) adj++;
        check("div1_bits_alternate", adj, 55);

        check("latch_sclk_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
